// File: rtl/cfu_master_if.sv
// Handshake bundle between a CFU master and a custom function unit.
//   req_*  : request channel (valid/ready), master -> CFU
//   resp_* : response channel (valid/ready), CFU -> master
// Parameters: ID_W transaction ID width, FUNC_W function ID width,
//             STATUS_W response status width.
interface cfu_interface #(
  parameter int unsigned ID_W     = 2,
  parameter int unsigned FUNC_W   = 10,
  parameter int unsigned STATUS_W = 2
);

  logic                req_valid;
  logic                req_ready;
  logic [ID_W-1:0]     req_id;
  logic [FUNC_W-1:0]   req_function_id;
  logic [31:0]         req_data0;
  logic [31:0]         req_data1;

  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [STATUS_W-1:0] resp_status;
  logic [31:0]         resp_data;

  modport master (
    output req_valid, req_id, req_function_id, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_id, req_function_id, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_status, resp_data
  );

endinterface

// File: rtl/cfu_master.sv
// CFU master: accepts instructions from the pipeline, presents them to the
// CFU through a single request register, buffers CFU responses in a FIFO and
// offers them to writeback in arrival order.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/issue_ready  instruction handshake from the pipeline
//   issue_id/fn/rs1/rs2      instruction payload
//   wb_valid/wb_ack          result handshake to writeback
//   wb_id/wb_data/wb_err     head-of-FIFO result
//   proto_err                sticky: response arrived with nothing outstanding
//   cfu                      request/response channels to the CFU
module cfu_master #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned RESP_DEPTH   = 2,
  parameter int unsigned FUNC_W       = 10,
  parameter int unsigned ID_W         = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ID_W-1:0]   issue_id,
  input  logic [FUNC_W-1:0] issue_fn,
  input  logic [31:0]       issue_rs1,
  input  logic [31:0]       issue_rs2,

  output logic              wb_valid,
  input  logic              wb_ack,
  output logic [ID_W-1:0]   wb_id,
  output logic [31:0]       wb_data,
  output logic              wb_err,

  output logic              proto_err,

  cfu_interface.master      cfu
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
  } resp_entry_t;

  // Request stage
  logic              req_valid_q;
  logic [ID_W-1:0]   req_id_q;
  logic [FUNC_W-1:0] req_fn_q;
  logic [31:0]       req_data0_q;
  logic [31:0]       req_data1_q;

  // Credit tracking
  logic [CNT_W-1:0]  inflight_q;

  // Response FIFO
  resp_entry_t       fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic              proto_err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              issue_fire;
  logic              resp_fire;
  logic              resp_orphan;
  logic              fifo_push;
  logic              fifo_pop;
  resp_entry_t       push_entry;
  resp_entry_t       head_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode
  assign fifo_full   = (occ_q == OCC_W'(RESP_DEPTH));
  assign fifo_empty  = (occ_q == '0);
  assign issue_ready = (!req_valid_q || cfu.req_ready) &&
                       (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign issue_fire  = issue_valid && issue_ready;
  assign resp_fire   = cfu.resp_valid && !fifo_full;
  // A response with no outstanding work and nothing buffered has no owner.
  assign resp_orphan = resp_fire && (inflight_q == '0) && fifo_empty;
  assign fifo_push   = resp_fire && !resp_orphan;
  assign fifo_pop    = !fifo_empty && wb_ack;

  assign push_entry.id   = cfu.resp_id;
  assign push_entry.data = cfu.resp_data;
  assign push_entry.err  = (cfu.resp_status != '0);

  // Request channel driven straight from the request register
  assign cfu.req_valid       = req_valid_q;
  assign cfu.req_id          = req_id_q;
  assign cfu.req_function_id = req_fn_q;
  assign cfu.req_data0       = req_data0_q;
  assign cfu.req_data1       = req_data1_q;
  assign cfu.resp_ready      = !fifo_full;

  // Request valid: set on accept, cleared once the CFU takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
    end else if (issue_fire) begin
      req_valid_q <= 1'b1;
    end else if (cfu.req_ready) begin
      req_valid_q <= 1'b0;
    end
  end

  // Request payload; only loaded on accept so it holds under backpressure
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      req_id_q    <= issue_id;
      req_fn_q    <= issue_fn;
      req_data0_q <= issue_rs1;
      req_data1_q <= issue_rs2;
    end
  end

  // Outstanding count from accept to writeback retire
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else if (issue_fire && !fifo_pop) begin
      inflight_q <= inflight_q + CNT_W'(1);
    end else if (!issue_fire && fifo_pop && (inflight_q != '0)) begin
      inflight_q <= inflight_q - CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (fifo_push && !fifo_pop) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (!fifo_push && fifo_pop) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end
  end

  // FIFO storage (not reset; validity is tracked by occupancy)
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (resp_orphan) begin
      proto_err_q <= 1'b1;
    end
  end

  // Writeback view of the FIFO head
  assign head_entry = fifo_mem[rd_ptr_q];
  assign wb_valid   = !fifo_empty;
  assign wb_id      = head_entry.id;
  assign wb_data    = head_entry.data;
  assign wb_err     = head_entry.err;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_cfu_master.sv
// Self-checking bench for cfu_master: directed scenarios followed by a
// randomized run, checked by a scoreboard-based monitor on the falling edge.
module tb_cfu_master;

  localparam int unsigned MAXI  = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned FW    = 10;
  localparam int unsigned IW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_id;
  logic [FW-1:0] issue_fn;
  logic [31:0]   issue_rs1;
  logic [31:0]   issue_rs2;
  logic          wb_valid;
  logic          wb_ack;
  logic [IW-1:0] wb_id;
  logic [31:0]   wb_data;
  logic          wb_err;
  logic          proto_err;

  logic          req_ready;
  logic          resp_valid;
  logic [IW-1:0] resp_id;
  logic [1:0]    resp_status;
  logic [31:0]   resp_data;

  always #5 clk = ~clk;

  cfu_interface #(.ID_W(IW), .FUNC_W(FW)) cif ();

  assign cif.req_ready   = req_ready;
  assign cif.resp_valid  = resp_valid;
  assign cif.resp_id     = resp_id;
  assign cif.resp_status = resp_status;
  assign cif.resp_data   = resp_data;

  cfu_master #(.MAX_INFLIGHT(MAXI), .RESP_DEPTH(DEPTH), .FUNC_W(FW), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_id    (issue_id),
    .issue_fn    (issue_fn),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .wb_valid    (wb_valid),
    .wb_ack      (wb_ack),
    .wb_id       (wb_id),
    .wb_data     (wb_data),
    .wb_err      (wb_err),
    .proto_err   (proto_err),
    .cfu         (cif)
  );

  // Reference model state
  typedef struct { logic [IW-1:0] id; logic [FW-1:0] fn; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { logic [IW-1:0] id; logic [31:0] data; logic err; } res_t;

  req_t          exp_req[$];   // accepted, not yet taken by the CFU
  res_t          sb[$];        // expected writeback results, in order
  logic [IW-1:0] pend[$];      // IDs the CFU owes a response for
  int            outstanding;
  logic          proto_exp;
  logic          last_resp_fire;
  int            n_issue;
  int            n_req_fire;

  int checks = 0;
  int errors = 0;

  // Manual response controls and auto-responder settings
  logic          auto_resp;
  int            resp_pct;
  logic          man_valid;
  logic [IW-1:0] man_id;
  logic [31:0]   man_data;
  logic [1:0]    man_status;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare DUT against the model, then apply this cycle's events
  logic m_ifire, m_rfire, m_sfire, m_wfire;
  int   m_out, m_sbn;
  req_t m_nr;
  res_t m_ns;

  always @(negedge clk) begin
    if (rst) begin
      exp_req.delete(); sb.delete(); pend.delete();
      outstanding    = 0;
      proto_exp      = 1'b0;
      last_resp_fire = 1'b0;
    end else begin
      m_out = outstanding;
      m_sbn = sb.size();
      chk("issue_ready", issue_ready, (exp_req.size() == 0 || req_ready) && (m_out < int'(MAXI)));
      chk("resp_ready", cif.resp_ready, m_sbn < int'(DEPTH));
      chk("wb_valid", wb_valid, m_sbn > 0);
      chk("req_valid", cif.req_valid, exp_req.size() > 0);
      chk("proto_err", proto_err, proto_exp);
      if (wb_valid && m_sbn > 0)
        chk("wb_result", {wb_id, wb_data, wb_err}, {sb[0].id, sb[0].data, sb[0].err});
      if (cif.req_valid && exp_req.size() > 0)
        chk("req_payload", {cif.req_id, cif.req_function_id, cif.req_data0, cif.req_data1},
            {exp_req[0].id, exp_req[0].fn, exp_req[0].a, exp_req[0].b});

      m_ifire = issue_valid && issue_ready;
      m_rfire = cif.req_valid && req_ready;
      m_sfire = resp_valid && cif.resp_ready;
      m_wfire = wb_valid && wb_ack;

      if (m_rfire && exp_req.size() > 0) begin
        pend.push_back(exp_req[0].id);
        void'(exp_req.pop_front());
        n_req_fire++;
      end
      if (m_sfire) begin
        if (m_out == 0 && m_sbn == 0) begin
          proto_exp = 1'b1;
        end else begin
          m_ns.id = resp_id; m_ns.data = resp_data; m_ns.err = (resp_status != 2'd0);
          sb.push_back(m_ns);
          for (int i = 0; i < pend.size(); i++) begin
            if (pend[i] == resp_id) begin
              pend.delete(i);
              break;
            end
          end
        end
      end
      if (m_wfire && m_sbn > 0) begin
        void'(sb.pop_front());
        if (outstanding > 0) outstanding--;
      end
      if (m_ifire) begin
        m_nr.id = issue_id; m_nr.fn = issue_fn; m_nr.a = issue_rs1; m_nr.b = issue_rs2;
        exp_req.push_back(m_nr);
        outstanding++;
        n_issue++;
      end
      last_resp_fire = m_sfire;
    end
  end

  // CFU responder: replays manual controls or answers pending IDs in random order
  initial begin
    resp_valid = 1'b0; resp_id = '0; resp_status = '0; resp_data = '0;
    forever begin
      @(posedge clk); #2;
      if (!auto_resp) begin
        resp_valid = man_valid; resp_id = man_id; resp_data = man_data; resp_status = man_status;
      end else if (resp_valid && !last_resp_fire) begin
        // hold the offered response until it is taken
      end else if (pend.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
        resp_id     = pend[$urandom_range(pend.size() - 1)];
        resp_data   = $urandom;
        resp_status = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
        resp_valid  = 1'b1;
      end else begin
        resp_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rand_issue();
    issue_id  = IW'($urandom);
    issue_fn  = FW'($urandom);
    issue_rs1 = $urandom;
    issue_rs2 = $urandom;
  endtask

  task automatic drain();
    int n;
    issue_valid = 1'b0; req_ready = 1'b1; wb_ack = 1'b1;
    auto_resp = 1'b1; resp_pct = 100;
    n = 0;
    while ((exp_req.size() > 0 || pend.size() > 0 || sb.size() > 0 || outstanding > 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 200, 1'b1);
    auto_resp = 1'b0; wb_ack = 1'b0;
    step(); step();
  endtask

  task automatic man_resp(input logic [IW-1:0] id, input logic [31:0] d, input logic [1:0] st);
    man_valid = 1'b1; man_id = id; man_data = d; man_status = st;
  endtask

  task automatic reset_pulse();
    auto_resp = 1'b0; man_valid = 1'b0;
    issue_valid = 1'b0; wb_ack = 1'b0; req_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int n0;

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_id = '0; issue_fn = '0; issue_rs1 = '0; issue_rs2 = '0;
    wb_ack = 1'b0; req_ready = 1'b1;
    auto_resp = 1'b0; resp_pct = 0; man_valid = 1'b0; man_id = '0; man_data = '0; man_status = '0;
    n_issue = 0; n_req_fire = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_req_valid", cif.req_valid, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_proto", proto_err, 1'b0);
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_resp_ready", cif.resp_ready, 1'b1);

    // Single operation
    issue_valid = 1'b1; issue_id = 2'd1; issue_fn = '0; issue_rs1 = 32'h1234_5678; issue_rs2 = '0;
    step();
    issue_valid = 1'b0;
    chk("single_req_valid", cif.req_valid, 1'b1);
    step();
    man_resp(2'd1, 32'hABCD_0000, 2'd0);
    step();
    man_valid = 1'b0;
    chk("single_wb", {wb_valid, wb_id, wb_data, wb_err}, {1'b1, 2'd1, 32'hABCD_0000, 1'b0});
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    chk("single_retired", wb_valid, 1'b0);
    drain();

    // Request backpressure
    n0 = n_req_fire;
    req_ready = 1'b0; issue_valid = 1'b1; rand_issue();
    step();
    for (int i = 0; i < 5; i++) begin
      rand_issue();
      chk("bp_issue_ready", issue_ready, 1'b0);
      step();
    end
    issue_valid = 1'b0; req_ready = 1'b1;
    step();
    chk("bp_req_cleared", cif.req_valid, 1'b0);
    step();
    chk("bp_one_request", n_req_fire - n0, 1);
    drain();

    // Credit limit with writeback stalled
    n0 = n_issue;
    req_ready = 1'b1; wb_ack = 1'b0; auto_resp = 1'b1; resp_pct = 100; issue_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_issue();
      step();
    end
    chk("credit_issues", n_issue - n0, MAXI);
    chk("credit_blocked", issue_ready, 1'b0);
    issue_valid = 1'b0; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    chk("credit_returned", issue_ready, 1'b1);
    drain();

    // Response FIFO full, simultaneous pop and offered push
    req_ready = 1'b1; issue_valid = 1'b1; rand_issue();
    for (int i = 0; i < 3; i++) begin
      issue_id = IW'(i);
      step();
    end
    issue_valid = 1'b0;
    step();
    man_resp(2'd0, 32'h0000_0A00, 2'd0);
    step();
    man_resp(2'd1, 32'h0000_0A01, 2'd0);
    step();
    man_valid = 1'b0;
    chk("full_resp_ready", cif.resp_ready, 1'b0);
    man_resp(2'd2, 32'h0000_0A02, 2'd0);
    wb_ack = 1'b1;
    chk("full_pop_cycle", cif.resp_ready, 1'b0);
    step();
    wb_ack = 1'b0;
    chk("full_after_pop", cif.resp_ready, 1'b1);
    step();
    man_valid = 1'b0;
    wb_ack = 1'b1;
    chk("order_id1", wb_id, 2'd1);
    step();
    chk("order_id2", wb_id, 2'd2);
    step();
    wb_ack = 1'b0;
    chk("order_empty", wb_valid, 1'b0);
    drain();

    // Error status
    issue_valid = 1'b1; rand_issue(); issue_id = 2'd3;
    step();
    issue_valid = 1'b0;
    step();
    man_resp(2'd3, 32'hDEAD_BEEF, 2'd3);
    step();
    man_valid = 1'b0;
    chk("err_wb", {wb_valid, wb_id, wb_err}, {1'b1, 2'd3, 1'b1});
    drain();

    // Orphan response after reset
    reset_pulse();
    man_resp(2'd2, 32'h5555_AAAA, 2'd0);
    step();
    man_valid = 1'b0;
    chk("proto_set", proto_err, 1'b1);
    chk("proto_no_wb", wb_valid, 1'b0);
    repeat (3) step();
    chk("proto_sticky", proto_err, 1'b1);
    reset_pulse();
    chk("proto_cleared", proto_err, 1'b0);

    // Reset with requests in flight
    req_ready = 1'b1; issue_valid = 1'b1;
    rand_issue(); step();
    rand_issue(); step();
    issue_valid = 1'b0;
    step();
    reset_pulse();
    chk("midrst_outputs", {cif.req_valid, wb_valid, proto_err, issue_ready, cif.resp_ready},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    step();
    chk("midrst_quiet", cif.req_valid, 1'b0);

    // Randomized traffic with out-of-order CFU completion
    auto_resp = 1'b1; resp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      issue_valid = 1'($urandom_range(1));
      rand_issue();
      req_ready = ($urandom_range(99) < 70);
      wb_ack    = ($urandom_range(99) < 60);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
